mem_bus_arbiter: RTL and testbench

Two-master arbiter for the native picorv32-style memory bus (valid/ready, 32-bit addr/data, 4-bit wstrb). It sits between the CPU and a second bus master, such as a future DMA or debug loader, and the single shared slave bus. That slave bus feeds the existing address decode to SRAM, LEDs and systick. It grants one master at a time, holds the grant until the slave completes, and alternates grants round-robin under contention.

---
 rtl/mem_bus_arbiter_pkg.sv | 23 ++
 rtl/mem_bus_arbiter_if.sv | 23 ++
 rtl/mem_bus_arbiter_timeout_ctr.sv | 34 +++
 rtl/mem_bus_arbiter.sv | 117 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arb_pkg: shared definitions for the two-master memory bus arbiter.
//   - bus widths of the native valid/ready memory bus
//   - default read data returned on an aborted transfer
//   - master index encoding used by the round-robin pointer
//   - arbiter FSM state type
package mem_bus_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

   localparam logic M0_IDX = 1'b0;
   localparam logic M1_IDX = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_if: one native memory bus link (picorv32-style valid/ready).
//   valid  request from the initiator
//   addr   byte address
//   wdata  write data
//   wstrb  byte strobes, all-zero means read
//   ready  completion from the target
//   rdata  read data from the target
// Modports:
//   master  the side that initiates a transfer
//   slave   the side that completes a transfer
interface mem_bus_if
   import mem_bus_arb_pkg::*;
   ;
   logic              valid;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              ready;
   logic [DATA_W-1:0] rdata;

   modport master (output valid, addr, wdata, wstrb, input ready, rdata);
   modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_bus_arbiter_timeout_ctr.sv
// bus_timeout_ctr: cycle counter that flags when a granted transfer has
// waited LIMIT-1 cycles. Only instantiated when MEM_BUS_ARB_TIMEOUT_EN is set.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   clear    hold the count at zero
//   en       advance the count by one
//   expired  count has reached LIMIT-1
module bus_timeout_ctr #(
   parameter int unsigned LIMIT = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         cnt <= '0;
      end else if (en && (cnt != LAST)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: grants one of two bus masters access to the shared slave
// bus, holds the grant until the slave completes, and alternates grants
// round-robin when both masters request in the same cycle.
// Optional feature macro: MEM_BUS_ARB_TIMEOUT_EN (abort a grant that waits
// TIMEOUT_CYCLES-1 cycles without s_ready; otherwise a grant waits forever).
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   m0       master 0 (CPU) bus, slave side
//   m1       master 1 (DMA / loader) bus, slave side
//   s        shared slave bus, master side
//   bus_err  one-cycle pulse on a timeout abort
module mem_bus_arbiter
   import mem_bus_arb_pkg::*;
#(
   parameter int unsigned       TIMEOUT_CYCLES = 1024,
   parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
   input  logic       clk,
   input  logic       reset_n,
   mem_bus_if.slave   m0,
   mem_bus_if.slave   m1,
   mem_bus_if.master  s,
   output logic       bus_err
);

   arb_state_t state, state_nxt;
   logic       last_gnt, last_gnt_nxt;
   logic       abort;

   if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
      $error("mem_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
   end

`ifdef MEM_BUS_ARB_TIMEOUT_EN
   logic expired;

   // Count stays at zero while idle, so every grant starts from zero.
   bus_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state == IDLE),
      .en      ((state != IDLE) && !s.ready),
      .expired (expired)
   );

   // A completion arriving in the expiry cycle takes precedence.
   assign abort = (state != IDLE) && expired && !s.ready;
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         last_gnt <= M1_IDX;
      end else begin
         state    <= state_nxt;
         last_gnt <= last_gnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      last_gnt_nxt = last_gnt;
      s.valid      = 1'b0;
      s.addr       = '0;
      s.wdata      = '0;
      s.wstrb      = '0;
      m0.ready     = 1'b0;
      m1.ready     = 1'b0;
      bus_err      = 1'b0;
      m0.rdata     = (abort && state == GNT0) ? ERR_RDATA : s.rdata;
      m1.rdata     = (abort && state == GNT1) ? ERR_RDATA : s.rdata;

      case (state)
         IDLE: begin
            // The round-robin pointer only moves on a tie.
            if (m0.valid && m1.valid) begin
               if (last_gnt == M1_IDX) begin
                  state_nxt    = GNT0;
                  last_gnt_nxt = M0_IDX;
               end else begin
                  state_nxt    = GNT1;
                  last_gnt_nxt = M1_IDX;
               end
            end else if (m0.valid) begin
               state_nxt = GNT0;
            end else if (m1.valid) begin
               state_nxt = GNT1;
            end
         end
         GNT0: begin
            s.valid  = 1'b1;
            s.addr   = m0.addr;
            s.wdata  = m0.wdata;
            s.wstrb  = m0.wstrb;
            m0.ready = s.ready || abort;
            bus_err  = abort;
            if (s.ready || abort) state_nxt = IDLE;
         end
         GNT1: begin
            s.valid  = 1'b1;
            s.addr   = m1.addr;
            s.wdata  = m1.wdata;
            s.wstrb  = m1.wstrb;
            m1.ready = s.ready || abort;
            bus_err  = abort;
            if (s.ready || abort) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed table-driven bench for mem_bus_arbiter plus
// hand-written sequences for reset-in-grant and long-stall / timeout cases.
module tb_mem_bus_arbiter;

   logic clk = 1'b0;
   logic reset_n;
   logic bus_err;

   mem_bus_if m0_bus ();
   mem_bus_if m1_bus ();
   mem_bus_if s_bus ();

   mem_bus_arbiter #(
      .TIMEOUT_CYCLES (8),
      .ERR_RDATA      (32'hDEAD_BEEF)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .m0      (m0_bus.slave),
      .m1      (m1_bus.slave),
      .s       (s_bus.master),
      .bus_err (bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        m0v;
      logic [31:0] m0a;
      logic [31:0] m0wd;
      logic [3:0]  m0ws;
      logic        m1v;
      logic [31:0] m1a;
      logic [31:0] m1wd;
      logic [3:0]  m1ws;
      logic        sr;
      logic [31:0] srd;
      logic        esv;
      logic [31:0] esa;
      logic [31:0] esw;
      logic [3:0]  esws;
      logic        em0r;
      logic        em1r;
   } vec_t;

   vec_t vecs[64];
   int   nvec = 0;
   int   total = 0;
   int   bad = 0;

   task automatic push(input vec_t v);
      vecs[nvec] = v;
      nvec++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_m0(input logic v, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
      m0_bus.valid = v;
      m0_bus.addr  = a;
      m0_bus.wdata = wd;
      m0_bus.wstrb = ws;
   endtask

   task automatic drive_m1(input logic v, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
      m1_bus.valid = v;
      m1_bus.addr  = a;
      m1_bus.wdata = wd;
      m1_bus.wstrb = ws;
   endtask

   task automatic drive_s(input logic r, input logic [31:0] d);
      s_bus.ready = r;
      s_bus.rdata = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int hold_bad;

      // Single m0 read, slave completes on the third grant cycle.
      push('{1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0, 4'h0, 1'b0, 1'b0});
      push('{1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,        1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0});
      push('{1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,        1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0});
      push('{1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h12345678, 1'b1, 32'h100, 32'h0, 4'h0, 1'b1, 1'b0});
      push('{1'b0, 32'h0,   32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0, 4'h0, 1'b0, 1'b0});

      // Sustained contention; s_ready held high also covers "ignored while idle".
      for (int i = 0; i < 4; i++) begin
         push('{1'b1, 32'hA0, 32'hA0A0, 4'h3, 1'b1, 32'hB0, 32'hB0B0, 4'hC, 1'b1, 32'hC0DE_0000 + i, 1'b0, 32'h0,  32'h0,    4'h0, 1'b0, 1'b0});
         push('{1'b1, 32'hA0, 32'hA0A0, 4'h3, 1'b1, 32'hB0, 32'hB0B0, 4'hC, 1'b1, 32'hC0DE_1000 + i, 1'b1, 32'hA0, 32'hA0A0, 4'h3, 1'b1, 1'b0});
         push('{1'b1, 32'hA0, 32'hA0A0, 4'h3, 1'b1, 32'hB0, 32'hB0B0, 4'hC, 1'b1, 32'hC0DE_2000 + i, 1'b0, 32'h0,  32'h0,    4'h0, 1'b0, 1'b0});
         push('{1'b1, 32'hA0, 32'hA0A0, 4'h3, 1'b1, 32'hB0, 32'hB0B0, 4'hC, 1'b1, 32'hC0DE_3000 + i, 1'b1, 32'hB0, 32'hB0B0, 4'hC, 1'b0, 1'b1});
      end
      push('{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0});

      // m1 byte write; m0 arrives mid-transfer and waits for m1_ready.
      push('{1'b0, 32'h0,   32'h0,  4'h0, 1'b1, 32'h8000_0000, 32'h3F, 4'h1, 1'b0, 32'h0,  1'b0, 32'h0,         32'h0,  4'h0, 1'b0, 1'b0});
      push('{1'b0, 32'h0,   32'h0,  4'h0, 1'b1, 32'h8000_0000, 32'h3F, 4'h1, 1'b0, 32'h0,  1'b1, 32'h8000_0000, 32'h3F, 4'h1, 1'b0, 1'b0});
      push('{1'b1, 32'h200, 32'h55, 4'hF, 1'b1, 32'h8000_0000, 32'h3F, 4'h1, 1'b0, 32'h0,  1'b1, 32'h8000_0000, 32'h3F, 4'h1, 1'b0, 1'b0});
      push('{1'b1, 32'h200, 32'h55, 4'hF, 1'b1, 32'h8000_0000, 32'h3F, 4'h1, 1'b1, 32'h77, 1'b1, 32'h8000_0000, 32'h3F, 4'h1, 1'b0, 1'b1});
      push('{1'b1, 32'h200, 32'h55, 4'hF, 1'b0, 32'h0,         32'h0,  4'h0, 1'b0, 32'h0,  1'b0, 32'h0,         32'h0,  4'h0, 1'b0, 1'b0});
      push('{1'b1, 32'h200, 32'h55, 4'hF, 1'b0, 32'h0,         32'h0,  4'h0, 1'b1, 32'h99, 1'b1, 32'h200,       32'h55, 4'hF, 1'b1, 1'b0});
      push('{1'b0, 32'h0,   32'h0,  4'h0, 1'b0, 32'h0,         32'h0,  4'h0, 1'b0, 32'h0,  1'b0, 32'h0,         32'h0,  4'h0, 1'b0, 1'b0});

      // Reset state.
      reset_n = 1'b0;
      drive_m0(1'b0, 32'h0, 32'h0, 4'h0);
      drive_m1(1'b0, 32'h0, 32'h0, 4'h0);
      drive_s(1'b0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset s_valid", {31'h0, s_bus.valid}, 32'h0);
      chk("reset s_addr", s_bus.addr, 32'h0);
      chk("reset s_wdata", s_bus.wdata, 32'h0);
      chk("reset s_wstrb", {28'h0, s_bus.wstrb}, 32'h0);
      chk("reset m0_ready", {31'h0, m0_bus.ready}, 32'h0);
      chk("reset m1_ready", {31'h0, m1_bus.ready}, 32'h0);
      chk("reset bus_err", {31'h0, bus_err}, 32'h0);
      reset_n = 1'b1;

      for (int i = 0; i < nvec; i++) begin
         drive_m0(vecs[i].m0v, vecs[i].m0a, vecs[i].m0wd, vecs[i].m0ws);
         drive_m1(vecs[i].m1v, vecs[i].m1a, vecs[i].m1wd, vecs[i].m1ws);
         drive_s(vecs[i].sr, vecs[i].srd);
         #1;
         chk($sformatf("row%0d s_valid", i), {31'h0, s_bus.valid}, {31'h0, vecs[i].esv});
         chk($sformatf("row%0d s_addr", i), s_bus.addr, vecs[i].esa);
         chk($sformatf("row%0d s_wdata", i), s_bus.wdata, vecs[i].esw);
         chk($sformatf("row%0d s_wstrb", i), {28'h0, s_bus.wstrb}, {28'h0, vecs[i].esws});
         chk($sformatf("row%0d m0_ready", i), {31'h0, m0_bus.ready}, {31'h0, vecs[i].em0r});
         chk($sformatf("row%0d m1_ready", i), {31'h0, m1_bus.ready}, {31'h0, vecs[i].em1r});
         chk($sformatf("row%0d m0_rdata", i), m0_bus.rdata, vecs[i].srd);
         chk($sformatf("row%0d m1_rdata", i), m1_bus.rdata, vecs[i].srd);
         chk($sformatf("row%0d bus_err", i), {31'h0, bus_err}, 32'h0);
         step();
      end

      // Reset while granted to m0 (pointer now favours m1); afterwards a tie
      // must again go to m0 because reset restores the pointer.
      drive_m0(1'b1, 32'hA0, 32'hA0A0, 4'h3);
      drive_m1(1'b1, 32'hB0, 32'hB0B0, 4'hC);
      drive_s(1'b0, 32'h0);
      step();
      chk("pre-reset grant addr", s_bus.addr, 32'hA0);
      reset_n = 1'b0;
      step();
      drive_s(1'b1, 32'h5A5A_5A5A);
      #1;
      chk("rst-in-gnt s_valid", {31'h0, s_bus.valid}, 32'h0);
      chk("rst-in-gnt s_addr", s_bus.addr, 32'h0);
      chk("rst-in-gnt s_wdata", s_bus.wdata, 32'h0);
      chk("rst-in-gnt s_wstrb", {28'h0, s_bus.wstrb}, 32'h0);
      chk("rst-in-gnt m0_ready", {31'h0, m0_bus.ready}, 32'h0);
      chk("rst-in-gnt m1_ready", {31'h0, m1_bus.ready}, 32'h0);
      chk("rst-in-gnt bus_err", {31'h0, bus_err}, 32'h0);
      reset_n = 1'b1;
      drive_s(1'b0, 32'h0);
      step();
      chk("post-reset tie s_valid", {31'h0, s_bus.valid}, 32'h1);
      chk("post-reset tie s_addr", s_bus.addr, 32'hA0);
      drive_s(1'b1, 32'h1357_9BDF);
      #1;
      chk("post-reset tie m0_ready", {31'h0, m0_bus.ready}, 32'h1);
      chk("post-reset tie m1_ready", {31'h0, m1_bus.ready}, 32'h0);
      chk("post-reset tie m0_rdata", m0_bus.rdata, 32'h1357_9BDF);
      step();
      drive_m0(1'b0, 32'h0, 32'h0, 4'h0);
      drive_m1(1'b0, 32'h0, 32'h0, 4'h0);
      drive_s(1'b0, 32'h0);
      step();

`ifdef MEM_BUS_ARB_TIMEOUT_EN
      // Slave never ready: abort on grant cycle 8 (request seen at cycle 0).
      drive_m0(1'b1, 32'h300, 32'h0, 4'h0);
      drive_s(1'b0, 32'h1111_2222);
      step();
      hold_bad = 0;
      for (int c = 1; c < 8; c++) begin
         if (s_bus.valid !== 1'b1 || m0_bus.ready !== 1'b0 || bus_err !== 1'b0) hold_bad++;
         step();
      end
      chk("timeout wait cycles", hold_bad, 0);
      chk("timeout s_valid", {31'h0, s_bus.valid}, 32'h1);
      chk("timeout m0_ready", {31'h0, m0_bus.ready}, 32'h1);
      chk("timeout m0_rdata", m0_bus.rdata, 32'hDEAD_BEEF);
      chk("timeout bus_err", {31'h0, bus_err}, 32'h1);
      chk("timeout m1_ready", {31'h0, m1_bus.ready}, 32'h0);
      step();
      drive_m0(1'b0, 32'h0, 32'h0, 4'h0);
      #1;
      chk("after timeout s_valid", {31'h0, s_bus.valid}, 32'h0);
      chk("after timeout bus_err", {31'h0, bus_err}, 32'h0);
      step();

      // s_ready in the expiry cycle wins: normal data, no bus_err.
      drive_m0(1'b1, 32'h304, 32'h0, 4'h0);
      drive_s(1'b0, 32'h0);
      step();
      repeat (7) step();
      drive_s(1'b1, 32'h600D_DA7A);
      #1;
      chk("coincide m0_ready", {31'h0, m0_bus.ready}, 32'h1);
      chk("coincide m0_rdata", m0_bus.rdata, 32'h600D_DA7A);
      chk("coincide bus_err", {31'h0, bus_err}, 32'h0);
      step();
      drive_m0(1'b0, 32'h0, 32'h0, 4'h0);
      drive_s(1'b0, 32'h0);
      step();
`else
      // Slave stalls 2000 cycles: grant held, no error, completion passes through.
      drive_m0(1'b1, 32'h300, 32'h0, 4'h0);
      drive_s(1'b0, 32'h0);
      step();
      hold_bad = 0;
      for (int c = 0; c < 2000; c++) begin
         if (s_bus.valid !== 1'b1 || s_bus.addr !== 32'h300 || m0_bus.ready !== 1'b0 || bus_err !== 1'b0) hold_bad++;
         step();
      end
      chk("stall grant held", hold_bad, 0);
      drive_s(1'b1, 32'hCAFE_F00D);
      #1;
      chk("stall m0_ready", {31'h0, m0_bus.ready}, 32'h1);
      chk("stall m0_rdata", m0_bus.rdata, 32'hCAFE_F00D);
      chk("stall bus_err", {31'h0, bus_err}, 32'h0);
      step();
      drive_m0(1'b0, 32'h0, 32'h0, 4'h0);
      drive_s(1'b0, 32'h0);
      #1;
      chk("after stall s_valid", {31'h0, s_bus.valid}, 32'h0);
      step();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
